// File: rtl/ex_mem_register.sv
// EX/MEM pipeline register.
//
// Captures execute-stage results for the memory stage with one cycle of latency.
// At each rising edge: Flush loads a bubble, otherwise Stall holds, otherwise the
// inputs are loaded. An invalid instruction still carries its data fields, but its
// side-effect controls are cleared, so Out_Valid=0 never causes a memory access,
// a register write or a control transfer. Bubble_Count saturates at all-ones.
//
// Ports:
//   Clock, Reset (async, active-low)  - clock and reset
//   Stall, Flush                      - hold / bubble-insert controls
//   In_*                              - execute-stage fields
//   Out_*                             - registered copies for the memory stage
//   Out_Valid                         - registered instruction-valid flag
//   Bubble_Count                      - number of bubbles loaded since reset
module ex_mem_register #(
  parameter int unsigned BUBBLE_CNT_W = 16
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    Stall,
  input  logic                    Flush,
  input  logic                    In_Valid,
  input  logic                    In_R_Enable,
  input  logic                    In_W_Enable,
  input  logic [1:0]              In_R_Width,
  input  logic [1:0]              In_W_Width,
  input  logic [3:0]              In_BranchSel,
  input  logic [31:0]             In_PC_Plus_Branch,
  input  logic                    In_Zero,
  input  logic [31:0]             In_ALUResult,
  input  logic [31:0]             In_Reg_Data2,
  input  logic [27:0]             In_j_sll_two,
  input  logic                    In_RegWrite,
  input  logic                    In_MemToReg,
  input  logic [4:0]              In_WriteReg,
  output logic                    Out_R_Enable,
  output logic                    Out_W_Enable,
  output logic [1:0]              Out_R_Width,
  output logic [1:0]              Out_W_Width,
  output logic [3:0]              Out_BranchSel,
  output logic [31:0]             Out_PC_Plus_Branch,
  output logic                    Out_Zero,
  output logic [31:0]             Out_ALUResult,
  output logic [31:0]             Out_Reg_Data2,
  output logic [27:0]             Out_j_sll_two,
  output logic                    Out_RegWrite,
  output logic                    Out_MemToReg,
  output logic [4:0]              Out_WriteReg,
  output logic                    Out_Valid,
  output logic [BUBBLE_CNT_W-1:0] Bubble_Count
);

  localparam logic [BUBBLE_CNT_W-1:0] CntMax = {BUBBLE_CNT_W{1'b1}};
  localparam logic [BUBBLE_CNT_W-1:0] CntOne = BUBBLE_CNT_W'(1);

  // Control fields (cleared on any bubble)
  logic                    valid_q, valid_d;
  logic                    r_enable_q, r_enable_d;
  logic                    w_enable_q, w_enable_d;
  logic [3:0]              branch_sel_q, branch_sel_d;
  logic                    reg_write_q, reg_write_d;
  logic                    mem_to_reg_q, mem_to_reg_d;
  // Data fields (cleared only on flush)
  logic [1:0]              r_width_q, r_width_d;
  logic [1:0]              w_width_q, w_width_d;
  logic [31:0]             pc_plus_branch_q, pc_plus_branch_d;
  logic                    zero_q, zero_d;
  logic [31:0]             alu_result_q, alu_result_d;
  logic [31:0]             reg_data2_q, reg_data2_d;
  logic [27:0]             j_sll_two_q, j_sll_two_d;
  logic [4:0]              write_reg_q, write_reg_d;
  logic [BUBBLE_CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

  logic [BUBBLE_CNT_W-1:0] bubble_cnt_inc;
  assign bubble_cnt_inc = (bubble_cnt_q == CntMax) ? bubble_cnt_q : bubble_cnt_q + CntOne;

  always_comb begin
    valid_d          = valid_q;
    r_enable_d       = r_enable_q;
    w_enable_d       = w_enable_q;
    branch_sel_d     = branch_sel_q;
    reg_write_d      = reg_write_q;
    mem_to_reg_d     = mem_to_reg_q;
    r_width_d        = r_width_q;
    w_width_d        = w_width_q;
    pc_plus_branch_d = pc_plus_branch_q;
    zero_d           = zero_q;
    alu_result_d     = alu_result_q;
    reg_data2_d      = reg_data2_q;
    j_sll_two_d      = j_sll_two_q;
    write_reg_d      = write_reg_q;
    bubble_cnt_d     = bubble_cnt_q;

    if (Flush) begin
      // Flush wins over Stall: full bubble, every field zeroed
      valid_d          = 1'b0;
      r_enable_d       = 1'b0;
      w_enable_d       = 1'b0;
      branch_sel_d     = 4'b0000;
      reg_write_d      = 1'b0;
      mem_to_reg_d     = 1'b0;
      r_width_d        = 2'b00;
      w_width_d        = 2'b00;
      pc_plus_branch_d = 32'h0;
      zero_d           = 1'b0;
      alu_result_d     = 32'h0;
      reg_data2_d      = 32'h0;
      j_sll_two_d      = 28'h0;
      write_reg_d      = 5'd0;
      bubble_cnt_d     = bubble_cnt_inc;
    end else if (!Stall) begin
      r_width_d        = In_R_Width;
      w_width_d        = In_W_Width;
      pc_plus_branch_d = In_PC_Plus_Branch;
      zero_d           = In_Zero;
      alu_result_d     = In_ALUResult;
      reg_data2_d      = In_Reg_Data2;
      j_sll_two_d      = In_j_sll_two;
      write_reg_d      = In_WriteReg;
      valid_d          = In_Valid;
      // Invalid slot keeps its data but must have no side effects
      r_enable_d       = In_Valid & In_R_Enable;
      w_enable_d       = In_Valid & In_W_Enable;
      reg_write_d      = In_Valid & In_RegWrite;
      mem_to_reg_d     = In_Valid & In_MemToReg;
      branch_sel_d     = In_Valid ? In_BranchSel : 4'b0000;
      if (!In_Valid) begin
        bubble_cnt_d = bubble_cnt_inc;
      end
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      valid_q          <= 1'b0;
      r_enable_q       <= 1'b0;
      w_enable_q       <= 1'b0;
      branch_sel_q     <= 4'b0000;
      reg_write_q      <= 1'b0;
      mem_to_reg_q     <= 1'b0;
      r_width_q        <= 2'b00;
      w_width_q        <= 2'b00;
      pc_plus_branch_q <= 32'h0;
      zero_q           <= 1'b0;
      alu_result_q     <= 32'h0;
      reg_data2_q      <= 32'h0;
      j_sll_two_q      <= 28'h0;
      write_reg_q      <= 5'd0;
      bubble_cnt_q     <= '0;
    end else begin
      valid_q          <= valid_d;
      r_enable_q       <= r_enable_d;
      w_enable_q       <= w_enable_d;
      branch_sel_q     <= branch_sel_d;
      reg_write_q      <= reg_write_d;
      mem_to_reg_q     <= mem_to_reg_d;
      r_width_q        <= r_width_d;
      w_width_q        <= w_width_d;
      pc_plus_branch_q <= pc_plus_branch_d;
      zero_q           <= zero_d;
      alu_result_q     <= alu_result_d;
      reg_data2_q      <= reg_data2_d;
      j_sll_two_q      <= j_sll_two_d;
      write_reg_q      <= write_reg_d;
      bubble_cnt_q     <= bubble_cnt_d;
    end
  end

  assign Out_Valid          = valid_q;
  assign Out_R_Enable       = r_enable_q;
  assign Out_W_Enable       = w_enable_q;
  assign Out_BranchSel      = branch_sel_q;
  assign Out_RegWrite       = reg_write_q;
  assign Out_MemToReg       = mem_to_reg_q;
  assign Out_R_Width        = r_width_q;
  assign Out_W_Width        = w_width_q;
  assign Out_PC_Plus_Branch = pc_plus_branch_q;
  assign Out_Zero           = zero_q;
  assign Out_ALUResult      = alu_result_q;
  assign Out_Reg_Data2      = reg_data2_q;
  assign Out_j_sll_two      = j_sll_two_q;
  assign Out_WriteReg       = write_reg_q;
  assign Bubble_Count       = bubble_cnt_q;

endmodule
